// File: rtl/global_header_writer_if.sv
// Signal bundle for global_header_writer: start/scene inputs, the 8-bit header stream and the
// object-emitter handshake. slave = writer side, master = scene-control / sink / emitter side.
interface global_header_writer_if #(
    parameter int OBJ_W = 8
);
    // Stream: a byte transfers on any rising edge where tvalid && tready. Once tvalid is high,
    // tdata/tlast hold until that transfer, and tvalid never drops mid-header.
    logic             start;
    logic [OBJ_W-1:0] obj_count;
    logic [7:0]       x_center;
    logic [7:0]       y_center;
    logic [7:0]       angle;
    logic [7:0]       zoom;
    logic [7:0]       tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;
    logic             obj_req;
    logic             obj_ack;
    logic             busy;
    logic             done;

    modport slave (
        input  start, obj_count, x_center, y_center, angle, zoom, tready, obj_ack,
        output tdata, tvalid, tlast, obj_req, busy, done
    );

    modport master (
        output start, obj_count, x_center, y_center, angle, zoom, tready, obj_ack,
        input  tdata, tvalid, tlast, obj_req, busy, done
    );
endinterface

// File: rtl/global_header_writer.sv
// Serialises the latched scene globals as a header byte stream, then requests one record per object.
// Optional macro CHECKSUM_EN appends an XOR checksum byte carrying TLAST.
module global_header_writer #(
    parameter int OBJ_W = 8
) (
    input  logic                  aclk,
    input  logic                  areset,
    global_header_writer_if.slave bus,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        OBJ  = 2'd2,
        FIN  = 2'd3
    } state_t;

`ifdef CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd5;
`else
    localparam logic [2:0] LAST_IDX = 3'd4;
`endif

    state_t           state_q;
    state_t           state_next;
    logic [2:0]       idx_q;
    logic [OBJ_W-1:0] count_q;
    logic [OBJ_W-1:0] remaining_q;
    logic [7:0]       x_q;
    logic [7:0]       y_q;
    logic [7:0]       angle_q;
    logic [7:0]       zoom_q;
    logic [7:0]       count8;
    logic [7:0]       hdr_byte;
    logic             hdr_last;

    assign dbg_state = state_q;
    assign hdr_last  = (idx_q == LAST_IDX);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_comb begin
        count8             = '0;
        count8[OBJ_W-1:0]  = count_q;
        hdr_byte           = 8'h00;
        case (idx_q)
            3'd0:    hdr_byte = count8;
            3'd1:    hdr_byte = x_q;
            3'd2:    hdr_byte = y_q;
            3'd3:    hdr_byte = angle_q;
            3'd4:    hdr_byte = zoom_q;
`ifdef CHECKSUM_EN
            3'd5:    hdr_byte = count8 ^ x_q ^ y_q ^ angle_q ^ zoom_q;
`endif
            default: hdr_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_next  = state_q;
        bus.tdata   = 8'h00;
        bus.tvalid  = 1'b0;
        bus.tlast   = 1'b0;
        bus.obj_req = 1'b0;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_next = HDR;
                end
            end
            HDR: begin
                bus.busy   = 1'b1;
                bus.tvalid = 1'b1;
                bus.tdata  = hdr_byte;
                bus.tlast  = hdr_last;
                if (bus.tready && hdr_last) begin
                    state_next = (count_q == '0) ? FIN : OBJ;
                end
            end
            OBJ: begin
                bus.busy    = 1'b1;
                bus.obj_req = 1'b1;
                if (bus.obj_ack && (remaining_q == OBJ_W'(1))) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                bus.busy   = 1'b1;
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Shadow registers are only written in IDLE, so later input changes cannot reach the stream.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            idx_q       <= 3'd0;
            count_q     <= '0;
            remaining_q <= '0;
            x_q         <= 8'h00;
            y_q         <= 8'h00;
            angle_q     <= 8'h00;
            zoom_q      <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        idx_q   <= 3'd0;
                        count_q <= bus.obj_count;
                        x_q     <= bus.x_center;
                        y_q     <= bus.y_center;
                        angle_q <= bus.angle;
                        zoom_q  <= bus.zoom;
                    end
                end
                HDR: begin
                    if (bus.tready) begin
                        idx_q <= idx_q + 3'd1;
                        if (hdr_last) begin
                            remaining_q <= count_q;
                        end
                    end
                end
                OBJ: begin
                    if (bus.obj_ack && (remaining_q != '0)) begin
                        remaining_q <= remaining_q - OBJ_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_global_header_writer.sv
// Directed bench for global_header_writer: stream bytes go through an expected queue checked by a
// negedge monitor; handshake timing, reset and completion are checked from the test sequence.
module tb_global_header_writer;

    localparam int OBJ_W = 8;
`ifdef CHECKSUM_EN
    localparam int HDR_LEN = 6;
`else
    localparam int HDR_LEN = 5;
`endif

    logic       aclk = 1'b0;
    logic       areset = 1'b1;
    logic [1:0] dbg_state;

    global_header_writer_if #(.OBJ_W(OBJ_W)) bus();

    global_header_writer #(.OBJ_W(OBJ_W)) dut (
        .aclk      (aclk),
        .areset    (areset),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    always #5 aclk = ~aclk;

    int         total = 0;
    int         bad = 0;
    logic [8:0] exp_q[$];
    int         hs_count = 0;
    bit         toggle_en = 1'b0;
    bit         hold_pending = 1'b0;
    bit         obj_req_seen = 1'b0;
    logic [8:0] held;
    int         cyc;
    int         busy_low;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the expected queue on every handshake and checks hold-while-stalled.
    always @(negedge aclk) begin
        logic [8:0] e;
        if (areset) begin
            hold_pending = 1'b0;
        end else begin
            if (bus.obj_req) obj_req_seen = 1'b1;
            if (hold_pending) begin
                check("hold_valid", bus.tvalid, 1);
                check("hold_data", {bus.tlast, bus.tdata}, held);
            end
            if (bus.tvalid && bus.tready) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_byte: got %0h expected none at %0t",
                             {bus.tlast, bus.tdata}, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_byte", {bus.tlast, bus.tdata}, e);
                end
            end
            hold_pending = bus.tvalid && !bus.tready;
            held         = {bus.tlast, bus.tdata};
        end
    end

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            if (toggle_en) bus.tready = ~bus.tready;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic push_header(input logic [7:0] cnt, input logic [7:0] x, input logic [7:0] y,
                               input logic [7:0] a, input logic [7:0] z);
        exp_q.push_back({1'b0, cnt});
        exp_q.push_back({1'b0, x});
        exp_q.push_back({1'b0, y});
        exp_q.push_back({1'b0, a});
`ifdef CHECKSUM_EN
        exp_q.push_back({1'b0, z});
        exp_q.push_back({1'b1, cnt ^ x ^ y ^ a ^ z});
`else
        exp_q.push_back({1'b1, z});
`endif
    endtask

    task automatic pulse_start(input logic [7:0] cnt, input logic [7:0] x, input logic [7:0] y,
                               input logic [7:0] a, input logic [7:0] z);
        @(posedge aclk);
        #1;
        bus.start     = 1'b1;
        bus.obj_count = cnt;
        bus.x_center  = x;
        bus.y_center  = y;
        bus.angle     = a;
        bus.zoom      = z;
        @(posedge aclk);
        #1;
        bus.start = 1'b0;
        @(negedge aclk);
        check("start_tvalid", bus.tvalid, 1);
        check("start_busy", bus.busy, 1);
    endtask

    task automatic wait_last(output int cycles, output int low);
        cycles = 0;
        low    = 0;
        while (!(bus.tvalid && bus.tready && bus.tlast) && cycles < 200) begin
            @(negedge aclk);
            cycles++;
            if (!bus.busy) low++;
        end
        if (cycles >= 200) begin
            total++;
            bad++;
            $display("FAIL last_timeout: got no TLAST handshake expected one within 200 cycles");
        end
    endtask

    task automatic do_acks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge aclk);
            #1;
            bus.obj_ack = 1'b1;
            @(posedge aclk);
            #1;
            bus.obj_ack = 1'b0;
            if (i < n - 1) begin
                @(negedge aclk);
                check("ack_mid_done", bus.done, 0);
                check("ack_mid_req", bus.obj_req, 1);
            end
        end
        @(negedge aclk);
        check("fin_done", bus.done, 1);
        check("fin_busy", bus.busy, 1);
        check("fin_req", bus.obj_req, 0);
        @(negedge aclk);
        check("idle_done", bus.done, 0);
        check("idle_busy", bus.busy, 0);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.obj_ack   = 1'b0;
        bus.tready    = 1'b1;
        bus.obj_count = '0;
        bus.x_center  = 8'h00;
        bus.y_center  = 8'h00;
        bus.angle     = 8'h00;
        bus.zoom      = 8'h00;

        // Reset state
        @(negedge aclk);
        check("rst_tvalid", bus.tvalid, 0);
        check("rst_tdata", bus.tdata, 0);
        check("rst_tlast", bus.tlast, 0);
        check("rst_req", bus.obj_req, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_state", dbg_state, 0);
        #2 areset = 1'b0;

        // 1: full-rate header, three objects
        push_header(8'h03, 8'h40, 8'h30, 8'h10, 8'h80);
        pulse_start(8'h03, 8'h40, 8'h30, 8'h10, 8'h80);
        wait_last(cyc, busy_low);
        check("t1_no_bubbles", cyc, HDR_LEN - 1);
        check("t1_busy_low", busy_low, 0);
        @(negedge aclk);
        check("t1_tvalid_drop", bus.tvalid, 0);
        check("t1_req", bus.obj_req, 1);
        do_acks(3);
        check("t1_queue_empty", exp_q.size(), 0);

        // 2: toggling backpressure
        hs_count = 0;
        toggle_en = 1'b1;
        push_header(8'h03, 8'h40, 8'h30, 8'h10, 8'h80);
        pulse_start(8'h03, 8'h40, 8'h30, 8'h10, 8'h80);
        wait_last(cyc, busy_low);
        toggle_en  = 1'b0;
        bus.tready = 1'b1;
        @(negedge aclk);
        check("t2_handshakes", hs_count, HDR_LEN);
        check("t2_req", bus.obj_req, 1);
        do_acks(3);
        check("t2_queue_empty", exp_q.size(), 0);

        // 3: zero objects, then back-to-back start one cycle after DONE
        obj_req_seen = 1'b0;
        push_header(8'h00, 8'h40, 8'h30, 8'h10, 8'h80);
        pulse_start(8'h00, 8'h40, 8'h30, 8'h10, 8'h80);
        wait_last(cyc, busy_low);
        @(negedge aclk);
        check("t3_done", bus.done, 1);
        check("t3_tvalid", bus.tvalid, 0);
        check("t3_no_req", obj_req_seen, 0);
        push_header(8'h02, 8'h11, 8'h22, 8'h33, 8'h44);
        pulse_start(8'h02, 8'h11, 8'h22, 8'h33, 8'h44);
        wait_last(cyc, busy_low);
        do_acks(2);
        check("t3_queue_empty", exp_q.size(), 0);

        // 4: START, input changes and OBJ_ACK during HDR are ignored
        bus.tready = 1'b0;
        push_header(8'h01, 8'h40, 8'h30, 8'h10, 8'h80);
        pulse_start(8'h01, 8'h40, 8'h30, 8'h10, 8'h80);
        @(posedge aclk);
        #1;
        bus.start     = 1'b1;
        bus.x_center  = 8'hFF;
        bus.obj_count = 8'h05;
        bus.obj_ack   = 1'b1;
        @(posedge aclk);
        #1;
        bus.start   = 1'b0;
        bus.obj_ack = 1'b0;
        bus.tready  = 1'b1;
        wait_last(cyc, busy_low);
        check("t4_busy_low", busy_low, 0);
        do_acks(1);
        check("t4_queue_empty", exp_q.size(), 0);

        // 5: reset while byte 2 is pending, then a clean restart
        bus.tready = 1'b1;
        exp_q.push_back({1'b0, 8'h03});
        exp_q.push_back({1'b0, 8'h40});
        pulse_start(8'h03, 8'h40, 8'h30, 8'h10, 8'h80);
        @(posedge aclk);
        @(posedge aclk);
        #1;
        bus.tready = 1'b0;
        @(negedge aclk);
        check("t5_pending_valid", bus.tvalid, 1);
        check("t5_pending_data", bus.tdata, 8'h30);
        #2 areset = 1'b1;
        #1;
        check("t5_rst_tvalid", bus.tvalid, 0);
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_tdata", bus.tdata, 0);
        check("t5_rst_state", dbg_state, 0);
        @(negedge aclk);
        #2 areset = 1'b0;
        check("t5_queue_drained", exp_q.size(), 0);
        bus.tready = 1'b1;
        push_header(8'h03, 8'h40, 8'h30, 8'h10, 8'h80);
        pulse_start(8'h03, 8'h40, 8'h30, 8'h10, 8'h80);
        wait_last(cyc, busy_low);
        do_acks(3);
        check("t5_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
